// File: rtl/xsim_innerprod_top.sv
// Inner-product simulation top: consumes header/payload request messages, accumulates
// signed 16x16 products into a wrapping 32-bit accumulator, and returns results through a FWFT FIFO.
module xsim_innerprod_top #(
    parameter int RSP_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        msgSink_src_rdy_b,
    input  logic [31:0] msgSink_beat_v,
    output logic        msgSink_dst_rdy,
    output logic        msgSource_src_rdy,
    output logic [31:0] msgSource_beat,
    input  logic        msgSource_dst_rdy_b,
    output logic        CLK_singleClock,
    output logic        CLK_GATE_singleClock,
    output logic        RST_N_singleReset
);
    localparam int AW = $clog2(RSP_DEPTH);
    localparam logic [AW:0] ROOM_LIM = (AW+1)'(RSP_DEPTH - 2);

    localparam logic [0:0] ST_HDR = 1'b0;
    localparam logic [0:0] ST_PAY = 1'b1;

    localparam logic [15:0] M_CLEAR  = 16'd0;
    localparam logic [15:0] M_DATA   = 16'd1;
    localparam logic [15:0] M_RESULT = 16'd2;
    localparam logic [31:0] RSP_HDR  = {16'h0001, 16'd1};

    logic [0:0]         state;
    logic [15:0]        method;
    logic [15:0]        remaining;
    logic signed [31:0] acc;

    logic [31:0]   fifoMem [RSP_DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] wrPtrNext;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   count;

    logic [15:0] curMethod;
    logic        completing;
    logic        resultDone;
    logic        fifoRoom;
    logic        sinkFire;
    logic        push;
    logic        pop;
    logic        doClear;
    logic        doData;

    // Signed 16x16 product of the two packed halves; the 32-bit result is exact.
    function automatic logic signed [31:0] mulPair(input logic [31:0] beat);
        logic signed [15:0] a;
        logic signed [15:0] b;
        a = beat[31:16];
        b = beat[15:0];
        return 32'(a) * 32'(b);
    endfunction

    // In HDR the incoming beat itself decides whether this transfer completes a message.
    always_comb begin
        curMethod  = (state == ST_HDR) ? msgSink_beat_v[31:16] : method;
        completing = (state == ST_HDR) ? (msgSink_beat_v[15:0] == 16'd0)
                                       : (remaining == 16'd1);
        resultDone = completing && (curMethod == M_RESULT);
        fifoRoom   = (count <= ROOM_LIM);
    end

    assign msgSink_dst_rdy = RST_N && !(resultDone && !fifoRoom);
    assign sinkFire        = msgSink_src_rdy_b && msgSink_dst_rdy;
    assign push            = sinkFire && resultDone;
    assign pop             = msgSource_dst_rdy_b && (count != '0);
    assign doClear         = sinkFire && completing && (curMethod == M_CLEAR);
    assign doData          = sinkFire && (state == ST_PAY) && (method == M_DATA);
    assign wrPtrNext       = wrPtr + AW'(1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_HDR;
            method    <= '0;
            remaining <= '0;
            acc       <= '0;
        end else begin
            if (doClear)
                acc <= '0;
            else if (doData)
                acc <= acc + mulPair(msgSink_beat_v);
            if (sinkFire) begin
                if (state == ST_HDR) begin
                    method <= msgSink_beat_v[31:16];
                    if (msgSink_beat_v[15:0] != 16'd0) begin
                        state     <= ST_PAY;
                        remaining <= msgSink_beat_v[15:0];
                    end
                end else begin
                    remaining <= remaining - 16'd1;
                    if (remaining == 16'd1)
                        state <= ST_HDR;
                end
            end
        end
    end

    // A RESULT pushes header and value together, so the write side advances by two.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push)
                wrPtr <= wrPtr + AW'(2);
            if (pop)
                rdPtr <= rdPtr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(2);
                2'b11:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifoMem[wrPtr]     <= RSP_HDR;
            fifoMem[wrPtrNext] <= acc;
        end
    end

    assign msgSource_src_rdy = (count != '0);
    assign msgSource_beat    = (count != '0) ? fifoMem[rdPtr] : 32'd0;

    assign CLK_singleClock      = CLK;
    assign CLK_GATE_singleClock = 1'b1;
    assign RST_N_singleReset    = RST_N;
endmodule

// File: tb/tb_xsim_innerprod_top.sv
// Randomized bench for xsim_innerprod_top against a message-level accumulator/response model.
module tb_xsim_innerprod_top;
    logic        CLK;
    logic        RST_N;
    logic        msgSink_src_rdy_b;
    logic [31:0] msgSink_beat_v;
    logic        msgSink_dst_rdy;
    logic        msgSource_src_rdy;
    logic [31:0] msgSource_beat;
    logic        msgSource_dst_rdy_b;
    logic        CLK_singleClock;
    logic        CLK_GATE_singleClock;
    logic        RST_N_singleReset;

    xsim_innerprod_top #(.RSP_DEPTH(4)) dut (
        .CLK                 (CLK),
        .RST_N               (RST_N),
        .msgSink_src_rdy_b   (msgSink_src_rdy_b),
        .msgSink_beat_v      (msgSink_beat_v),
        .msgSink_dst_rdy     (msgSink_dst_rdy),
        .msgSource_src_rdy   (msgSource_src_rdy),
        .msgSource_beat      (msgSource_beat),
        .msgSource_dst_rdy_b (msgSource_dst_rdy_b),
        .CLK_singleClock     (CLK_singleClock),
        .CLK_GATE_singleClock(CLK_GATE_singleClock),
        .RST_N_singleReset   (RST_N_singleReset)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          nChecks = 0;
    int          nErrors = 0;
    logic [31:0] mAcc;
    logic [31:0] expQ[$];
    logic [31:0] rxQ[$];
    logic [31:0] payQ[$];
    bit          randBp = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Record every source beat that will transfer on the coming rising edge.
    always begin
        @(negedge CLK);
        #2;
        if (RST_N && msgSource_src_rdy && msgSource_dst_rdy_b)
            rxQ.push_back(msgSource_beat);
    end

    always begin
        @(negedge CLK);
        if (randBp)
            msgSource_dst_rdy_b = ($urandom_range(3) != 0);
    end

    // Called right after a falling edge; returns right after a falling edge.
    task automatic sendBeat(input logic [31:0] b);
        int n = 0;
        msgSink_beat_v    = b;
        msgSink_src_rdy_b = 1'b1;
        #1;
        while (!msgSink_dst_rdy && n < 300) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (n >= 300)
            chk("sinkTimeout", 32'd0, 32'd1);
        @(negedge CLK);
        msgSink_src_rdy_b = 1'b0;
    endtask

    task automatic modelMsg(input logic [15:0] m);
        int a;
        int b;
        if (m == 16'd0) begin
            mAcc = 32'd0;
        end else if (m == 16'd1) begin
            foreach (payQ[i]) begin
                a    = $signed(payQ[i][31:16]);
                b    = $signed(payQ[i][15:0]);
                mAcc = mAcc + 32'(a * b);
            end
        end else if (m == 16'd2) begin
            expQ.push_back(32'h0001_0001);
            expQ.push_back(mAcc);
        end
    endtask

    // Sends header plus the beats currently in payQ and updates the model.
    task automatic sendMsg(input logic [15:0] m);
        sendBeat({m, 16'(payQ.size())});
        foreach (payQ[i]) sendBeat(payQ[i]);
        modelMsg(m);
        payQ.delete();
    endtask

    task automatic checkRx(input string tag);
        int n = 0;
        do begin
            @(negedge CLK);
            #3;
            n++;
        end while (n < 200 && (msgSource_src_rdy || rxQ.size() < expQ.size()));
        chk({tag, "_count"}, 32'(rxQ.size()), 32'(expQ.size()));
        foreach (expQ[i]) begin
            if (i < rxQ.size())
                chk($sformatf("%s_beat%0d", tag, i), rxQ[i], expQ[i]);
        end
        rxQ.delete();
        expQ.delete();
        @(negedge CLK);
    endtask

    task automatic applyReset(input int cycles);
        RST_N = 1'b0;
        repeat (cycles) @(negedge CLK);
        RST_N = 1'b1;
        mAcc = 32'd0;
        expQ.delete();
        rxQ.delete();
    endtask

    initial begin
        int op;
        int n;
        RST_N               = 1'b0;
        msgSink_src_rdy_b   = 1'b0;
        msgSink_beat_v      = 32'd0;
        msgSource_dst_rdy_b = 1'b1;
        mAcc                = 32'd0;

        // Idle after reset
        repeat (3) @(negedge CLK);
        #1;
        chk("rstSinkRdy", 32'(msgSink_dst_rdy), 32'd0);
        chk("rstSrcRdy", 32'(msgSource_src_rdy), 32'd0);
        chk("rstBeat", msgSource_beat, 32'd0);
        chk("rstPass", 32'(RST_N_singleReset), 32'd0);
        repeat (8) @(negedge CLK);
        applyReset(0);
        #1;
        chk("rstPassHi", 32'(RST_N_singleReset), 32'd1);
        chk("clkLo", 32'(CLK_singleClock), 32'(CLK));
        chk("gate", 32'(CLK_GATE_singleClock), 32'd1);
        @(posedge CLK);
        #1;
        chk("clkHi", 32'(CLK_singleClock), 32'(CLK));
        repeat (3) @(negedge CLK);
        #1;
        chk("idleSinkRdy", 32'(msgSink_dst_rdy), 32'd1);
        chk("idleSrcRdy", 32'(msgSource_src_rdy), 32'd0);
        @(negedge CLK);

        // Basic dot product: 6 - 4 + 25 = 27
        sendMsg(16'd0);
        payQ = '{32'h0002_0003, 32'h0004_FFFF, 32'h0005_0005};
        sendMsg(16'd1);
        sendMsg(16'd2);
        chk("basicModel", expQ[1], 32'h0000_001B);
        checkRx("basic");

        // Wraparound
        sendMsg(16'd0);
        payQ = '{32'h7FFF_7FFF, 32'h7FFF_7FFF};
        sendMsg(16'd1);
        sendMsg(16'd2);
        chk("wrapModel", expQ[1], 32'h7FFE_0002);
        checkRx("wrap");
        payQ = '{32'h7FFF_7FFF};
        sendMsg(16'd1);
        sendMsg(16'd2);
        checkRx("wrapNeg");

        // Backpressure: FIFO fills after two RESULTs, the third waits
        msgSource_dst_rdy_b = 1'b0;
        sendMsg(16'd2);
        sendMsg(16'd2);
        msgSink_beat_v    = 32'h0002_0000;
        msgSink_src_rdy_b = 1'b1;
        #1;
        chk("bpBlocked", 32'(msgSink_dst_rdy), 32'd0);
        chk("bpHead", msgSource_beat, 32'h0001_0001);
        @(negedge CLK);
        #1;
        chk("bpStillBlocked", 32'(msgSink_dst_rdy), 32'd0);
        chk("bpNoDrain", 32'(rxQ.size()), 32'd0);
        msgSource_dst_rdy_b = 1'b1;
        msgSink_src_rdy_b   = 1'b0;
        sendMsg(16'd2);
        checkRx("bp");
        #1;
        chk("bpReadyBack", 32'(msgSink_dst_rdy), 32'd1);
        @(negedge CLK);

        // Unknown method leaves the accumulator alone
        payQ = '{$urandom, $urandom};
        sendMsg(16'd7);
        sendMsg(16'd2);
        checkRx("unknown");

        // Reset mid-message with a queued response pending
        sendMsg(16'd0);
        payQ = '{32'h0003_0003};
        sendMsg(16'd1);
        msgSource_dst_rdy_b = 1'b0;
        sendMsg(16'd2);
        sendBeat(32'h0001_0003);
        sendBeat(32'h0004_0004);
        applyReset(2);
        #1;
        chk("midRstSrcRdy", 32'(msgSource_src_rdy), 32'd0);
        msgSource_dst_rdy_b = 1'b1;
        @(negedge CLK);
        sendMsg(16'd2);
        chk("midRstModel", expQ[1], 32'd0);
        checkRx("midRst");

        // Randomized messages under random source backpressure
        randBp = 1;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(3);
            n  = $urandom_range(4);
            if (op == 1 && n == 0) n = 1;
            for (int k = 0; k < n; k++) payQ.push_back($urandom);
            case (op)
                0:       sendMsg(16'd0);
                1:       sendMsg(16'd1);
                2:       sendMsg(16'd2);
                default: sendMsg(16'($urandom_range(16'hFFFF, 3)));
            endcase
            if (it % 8 == 7) checkRx($sformatf("rand%0d", it));
        end
        sendMsg(16'd2);
        randBp = 0;
        msgSource_dst_rdy_b = 1'b1;
        checkRx("randFinal");

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
